alu: RTL and testbench



---
 rtl/alu_if.sv | 29 ++
 rtl/alu.sv | 131 +++++++++++++
 tb/tb_alu.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_if.sv
// ============================================================================
// Module      : alu_if
// Description : Operand/opcode and result/flag bundle for the execute-stage ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_if;
    logic [3:0]  OpCode;
    logic [31:0] Op1;
    logic [31:0] Op2;
    logic [31:0] Out;
    logic        NFlag;
    logic        ZFlag;
    logic        CFlag;
    logic        VFlag;

    modport master (
        output OpCode, Op1, Op2,
        input  Out, NFlag, ZFlag, CFlag, VFlag
    );

    modport slave (
        input  OpCode, Op1, Op2,
        output Out, NFlag, ZFlag, CFlag, VFlag
    );
endinterface

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : 32-bit ARMv7 data-processing ALU with registered result/NZCV.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu (
    input  wire logic clk,
    input  wire logic rst,
    alu_if.slave      bus
);

    localparam logic [3:0] c_AND = 4'd0;
    localparam logic [3:0] c_EOR = 4'd1;
    localparam logic [3:0] c_SUB = 4'd2;
    localparam logic [3:0] c_RSB = 4'd3;
    localparam logic [3:0] c_ADD = 4'd4;
    localparam logic [3:0] c_ADC = 4'd5;
    localparam logic [3:0] c_SBC = 4'd6;
    localparam logic [3:0] c_RSC = 4'd7;
    localparam logic [3:0] c_TST = 4'd8;
    localparam logic [3:0] c_TEQ = 4'd9;
    localparam logic [3:0] c_CMP = 4'd10;
    localparam logic [3:0] c_CMN = 4'd11;
    localparam logic [3:0] c_ORR = 4'd12;
    localparam logic [3:0] c_MOV = 4'd13;
    localparam logic [3:0] c_BIC = 4'd14;
    localparam logic [3:0] c_MVN = 4'd15;

    logic [31:0] r_out;
    logic        r_n;
    logic        r_z;
    logic        r_c;
    logic        r_v;

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_cin;
    logic        w_arith;
    logic [32:0] w_sum;
    logic [31:0] w_result;
    logic        w_v;

    // Operand steering for the single shared adder: subtracts invert one side
    // and feed either a constant 1 or the held carry as the carry-in.
    always_comb begin
        w_a     = bus.Op1;
        w_b     = bus.Op2;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        case (bus.OpCode)
            c_SUB, c_CMP: begin
                w_b     = ~bus.Op2;
                w_cin   = 1'b1;
                w_arith = 1'b1;
            end
            c_RSB: begin
                w_a     = bus.Op2;
                w_b     = ~bus.Op1;
                w_cin   = 1'b1;
                w_arith = 1'b1;
            end
            c_ADD, c_CMN: begin
                w_arith = 1'b1;
            end
            c_ADC: begin
                w_cin   = r_c;
                w_arith = 1'b1;
            end
            c_SBC: begin
                w_b     = ~bus.Op2;
                w_cin   = r_c;
                w_arith = 1'b1;
            end
            c_RSC: begin
                w_a     = bus.Op2;
                w_b     = ~bus.Op1;
                w_cin   = r_c;
                w_arith = 1'b1;
            end
            default: begin
                w_arith = 1'b0;
            end
        endcase
    end

    assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {32'd0, w_cin};
    assign w_v   = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);

    always_comb begin
        w_result = w_sum[31:0];
        case (bus.OpCode)
            c_AND, c_TST: w_result = bus.Op1 & bus.Op2;
            c_EOR, c_TEQ: w_result = bus.Op1 ^ bus.Op2;
            c_ORR:        w_result = bus.Op1 | bus.Op2;
            c_MOV:        w_result = bus.Op2;
            c_BIC:        w_result = bus.Op1 & ~bus.Op2;
            c_MVN:        w_result = ~bus.Op2;
            default:      w_result = w_sum[31:0];
        endcase
    end

    // Logical/move ops keep the previous C and V.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= 32'd0;
            r_n   <= 1'b0;
            r_z   <= 1'b0;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
        end else begin
            r_out <= w_result;
            r_n   <= w_result[31];
            r_z   <= (w_result == 32'd0);
            if (w_arith) begin
                r_c <= w_sum[32];
                r_v <= w_v;
            end
        end
    end

    assign bus.Out   = r_out;
    assign bus.NFlag = r_n;
    assign bus.ZFlag = r_z;
    assign bus.CFlag = r_c;
    assign bus.VFlag = r_v;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module      : tb_alu
// Description : Directed self-checking bench for the ARM data-processing ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    alu_if u_if ();

    alu u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        u_if.OpCode = op;
        u_if.Op1    = a;
        u_if.Op2    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string tag, input logic [31:0] out, input logic [3:0] nzcv);
        chk({tag, "_out"}, u_if.Out, out);
        chk({tag, "_nzcv"}, {28'd0, u_if.NFlag, u_if.ZFlag, u_if.CFlag, u_if.VFlag}, {28'd0, nzcv});
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        step(4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_res("reset", 32'h0000_0000, 4'b0000);
        rst = 1'b0;

        step(4'd4, 32'h7FFF_FFFF, 32'h0000_0001);
        expect_res("add_ovf", 32'h8000_0000, 4'b1001);
        step(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        expect_res("and_hold", 32'hF000_F000, 4'b1001);
        step(4'd4, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_res("add_carry", 32'h0000_0000, 4'b0110);
        step(4'd5, 32'h0, 32'h0);
        expect_res("adc_cin1", 32'h0000_0001, 4'b0000);
        step(4'd2, 32'd5, 32'd5);
        expect_res("sub_eq", 32'h0000_0000, 4'b0110);
        step(4'd10, 32'd3, 32'd5);
        expect_res("cmp_borrow", 32'hFFFF_FFFE, 4'b1000);
        step(4'd6, 32'd10, 32'd3);
        expect_res("sbc_cin0", 32'h0000_0006, 4'b0010);
        step(4'd15, 32'h1234_5678, 32'h0);
        expect_res("mvn", 32'hFFFF_FFFF, 4'b1010);
        step(4'd14, 32'h0000_00FF, 32'h0000_000F);
        expect_res("bic", 32'h0000_00F0, 4'b0010);
        step(4'd3, 32'd2, 32'd7);
        expect_res("rsb", 32'h0000_0005, 4'b0010);
        step(4'd7, 32'd2, 32'd7);
        expect_res("rsc_cin1", 32'h0000_0005, 4'b0010);

        step(4'd1, 32'hFFFF_0000, 32'h0F0F_0F0F);
        expect_res("eor", 32'hF0F0_0F0F, 4'b1010);
        step(4'd12, 32'h0000_00F0, 32'h0000_0F00);
        expect_res("orr", 32'h0000_0FF0, 4'b0010);
        step(4'd13, 32'h0000_1111, 32'h8000_0000);
        expect_res("mov", 32'h8000_0000, 4'b1010);
        step(4'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        expect_res("teq", 32'h0000_0000, 4'b0110);
        step(4'd11, 32'h8000_0000, 32'h8000_0000);
        expect_res("cmn_cv", 32'h0000_0000, 4'b0111);
        step(4'd8, 32'h0000_0001, 32'h0000_0002);
        expect_res("tst_hold", 32'h0000_0000, 4'b0111);

        // Mid-stream reset must clear the carry seen by the next ADC.
        step(4'd4, 32'hFFFF_FFFF, 32'h0000_0002);
        expect_res("add_pre_rst", 32'h0000_0001, 4'b0010);
        rst = 1'b1;
        step(4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        expect_res("rst_mid", 32'h0000_0000, 4'b0000);
        rst = 1'b0;
        step(4'd5, 32'h0, 32'h0);
        expect_res("adc_after_rst", 32'h0000_0000, 4'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
